// File: rtl/keypad_scanner_if.sv
// Keypad scanner pin and result bundle: matrix row/column lines plus the decoded key outputs.
interface keypad_scanner_if;
    logic [3:0] COL;
    logic [3:0] ROW;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    modport master (
        input  COL,
        output ROW,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output COL,
        input  ROW,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with frame-based debounce, one key code per press.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 250000,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 32
) (
    input  logic             CCLK,
    input  logic             RST_N,
    keypad_scanner_if.master kp
);
    localparam int unsigned PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW  = $clog2(DEBOUNCE_FRAMES + 1);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_bad_deb
        $error("DEBOUNCE_FRAMES must be at least 1");
    end
    if (REPEAT_FRAMES < 1) begin : g_bad_rep
        $error("REPEAT_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [3:0]    col_s1, col_s2;
    logic [PW-1:0] presc_q;
    logic [1:0]    row_idx_q;
    logic [3:0]    row_q;
    logic [1:0]    acc_hits_q;
    logic [3:0]    acc_code_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          held_q, held_d;

    logic          step_c, frame_end_c;
    logic [2:0]    row_hits_c, sum_hits_c;
    logic [1:0]    row_col_c, frame_hits_c;
    logic [3:0]    frame_code_c;
    logic          none_c, single_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RPW = $clog2(REPEAT_FRAMES + 1);
    logic [RPW-1:0] rep_q, rep_d;
`endif

    assign step_c      = (presc_q == PW'(SCAN_DIV - 1));
    assign frame_end_c = step_c && (row_idx_q == 2'd3);

    // Low columns on the current row, folded into the running frame tally (saturates at 2 = MULTI)
    always_comb begin
        row_hits_c = 3'd0;
        row_col_c  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!col_s2[i]) begin
                row_hits_c = row_hits_c + 3'd1;
                row_col_c  = 2'(i);
            end
        end
        sum_hits_c   = {1'b0, acc_hits_q} + row_hits_c;
        frame_hits_c = (sum_hits_c >= 3'd2) ? 2'd2 : sum_hits_c[1:0];
        frame_code_c = (acc_hits_q == 2'd0) ? {row_idx_q, row_col_c} : acc_code_q;
        none_c       = (frame_hits_c == 2'd0);
        single_c     = (frame_hits_c == 2'd1);
    end

    // Column synchroniser, prescaler, row drive and per-frame accumulation
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            col_s1     <= 4'hF;
            col_s2     <= 4'hF;
            presc_q    <= '0;
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'd0;
        end else begin
            col_s1 <= kp.COL;
            col_s2 <= col_s1;
            if (step_c) begin
                presc_q   <= '0;
                row_idx_q <= row_idx_q + 2'd1;
                row_q     <= ~(4'b0001 << (row_idx_q + 2'd1));
                if (frame_end_c) begin
                    acc_hits_q <= 2'd0;
                    acc_code_q <= 4'd0;
                end else begin
                    acc_hits_q <= frame_hits_c;
                    acc_code_q <= frame_code_c;
                end
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= 4'd0;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Debounce FSM; only moves on the frame-end cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_end_c) begin
            case (state_q)
                IDLE: begin
                    if (single_c) begin
                        cand_d = frame_code_c;
                        cnt_d  = CW'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            code_d  = frame_code_c;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (single_c && (frame_code_c == cand_q)) begin
                        cnt_d = cnt_q + CW'(1);
                        if ((cnt_q + CW'(1)) == CW'(DEBOUNCE_FRAMES)) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (none_c) begin
                        cnt_d = CW'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_q == RPW'(REPEAT_FRAMES - 1)) begin
                            valid_d = 1'b1;
                            rep_d   = '0;
                        end else begin
                            rep_d = rep_q + RPW'(1);
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (none_c) begin
                        cnt_d = cnt_q + CW'(1);
                        if ((cnt_q + CW'(1)) == CW'(DEBOUNCE_FRAMES)) begin
                            held_d  = 1'b0;
                            state_d = IDLE;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign kp.ROW       = row_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad matrix model drives COL from ROW and pressed keys.
module tb_keypad_scanner;
    localparam int FR = 16;
`ifdef KEYPAD_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic CCLK  = 1'b0;
    logic RST_N = 1'b1;
    logic [15:0] keys = 16'h0000;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_FRAMES(2),
        .REPEAT_FRAMES(3)
    ) dut (
        .CCLK (CCLK),
        .RST_N(RST_N),
        .kp   (kif)
    );

    always #5 CCLK = ~CCLK;

    // Matrix model: a pressed key pulls its column low while its row is driven low
    always_comb begin
        kif.COL = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (kif.ROW[r] === 1'b0)) kif.COL[c] = 1'b0;
    end

    int unsigned cyc = 0;
    always @(posedge CCLK) cyc <= cyc + 1;

    logic [3:0]  obs_q[$];
    int unsigned obs_cyc[$];
    always @(negedge CCLK)
        if (RST_N && kif.key_valid === 1'b1) begin
            obs_q.push_back(kif.key_code);
            obs_cyc.push_back(cyc);
        end

    int n_checks = 0;
    int n_fail   = 0;
    int rd_idx   = 0;
    logic [3:0] exp_q[$];
    logic [3:0] e = 4'd0;

    task automatic wait_frames(input int n);
        repeat (n * FR) @(negedge CCLK);
    endtask

    task automatic wait_row(input logic [3:0] r);
        for (int i = 0; i < 40; i++) begin
            @(negedge CCLK);
            if (kif.ROW === r) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CCLK);
        RST_N = 1'b1;
        repeat (7) @(negedge CCLK);
        #2 RST_N = 1'b0;
        #1;
        n_checks++; if (kif.ROW !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b expected 1110", kif.ROW); end
        n_checks++; if (kif.key_code !== 4'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", kif.key_code); end
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", kif.key_valid); end
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 0", kif.key_held); end
        @(negedge CCLK);
        RST_N = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            logic [3:0] er;
            @(negedge CCLK);
            er = ~(4'b0001 << ((k / 4) % 4));
            n_checks++;
            if (kif.ROW !== er) begin n_fail++; $display("FAIL reset_row_seq: step %0d got %b expected %b", k, kif.ROW, er); end
        end
    endtask

    task automatic test_press();
        keys = 16'h0040;
        exp_q.push_back(4'd6);
        if (REP) exp_q.push_back(4'd6);
        wait_frames(5);
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL press_held: got %b expected 1", kif.key_held); end
        keys = 16'h0000;
        wait_frames(1);
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL press_held_one_none: got %b expected 1", kif.key_held); end
        wait_frames(3);
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL press_released: got %b expected 0", kif.key_held); end
        n_checks++; if (kif.key_code !== 4'd6) begin n_fail++; $display("FAIL press_code_kept: got %0d expected 6", kif.key_code); end
        n_checks++;
        if (obs_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("FAIL press_pulse_count: got %0d expected %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (obs_q[rd_idx] !== e) begin n_fail++; $display("FAIL press_pulse_code: got %0d expected %0d", obs_q[rd_idx], e); end
            rd_idx++;
        end
        exp_q.delete();
    endtask

    task automatic test_bounce();
        wait_row(4'b1110);
        keys = 16'h0001;
        repeat (3) @(negedge CCLK);
        keys = 16'h0000;
        wait_frames(4);
        n_checks++;
        if (obs_q.size() != rd_idx) begin n_fail++; $display("FAIL bounce_pulse: got %0d pulses expected 0", obs_q.size() - rd_idx); end
        rd_idx = obs_q.size();
        n_checks++; if (kif.key_code !== 4'd6) begin n_fail++; $display("FAIL bounce_code: got %0d expected 6", kif.key_code); end
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL bounce_held: got %b expected 0", kif.key_held); end
    endtask

    task automatic test_chord();
        keys = 16'h8200;
        wait_frames(6);
        n_checks++;
        if (obs_q.size() != rd_idx) begin n_fail++; $display("FAIL chord_pulse: got %0d pulses expected 0", obs_q.size() - rd_idx); end
        rd_idx = obs_q.size();
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL chord_held: got %b expected 0", kif.key_held); end
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        wait_frames(4);
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL chord_single_held: got %b expected 1", kif.key_held); end
        n_checks++; if (kif.key_code !== 4'd9) begin n_fail++; $display("FAIL chord_single_code: got %0d expected 9", kif.key_code); end
        keys = 16'h0000;
        wait_frames(4);
        n_checks++;
        if (!(obs_q.size() == rd_idx + exp_q.size() || (REP && obs_q.size() > rd_idx + exp_q.size()))) begin
            n_fail++; $display("FAIL chord_pulse_count: got %0d expected %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (obs_q[rd_idx] !== e) begin n_fail++; $display("FAIL chord_pulse_code: got %0d expected %0d", obs_q[rd_idx], e); end
            rd_idx++;
        end
        exp_q.delete();
    endtask

    task automatic test_release_glitch();
        keys = 16'h8000;
        exp_q.push_back(4'd15);
        wait_frames(4);
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_first_held: got %b expected 1", kif.key_held); end
        wait_row(4'b0111);
        wait_row(4'b1110);
        n_checks++; if (kif.ROW !== 4'b1110) begin n_fail++; $display("FAIL glitch_align: got %b expected 1110", kif.ROW); end
        keys = 16'h0000;
        wait_row(4'b0111);
        wait_row(4'b1110);
        keys = 16'h8000;
        wait_frames(3);
        n_checks++; if (kif.key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held_kept: got %b expected 1", kif.key_held); end
        n_checks++;
        if (!(obs_q.size() == rd_idx + exp_q.size() || (REP && obs_q.size() > rd_idx + exp_q.size()))) begin
            n_fail++; $display("FAIL glitch_pulse_count: got %0d expected %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (obs_q[rd_idx] !== e) begin n_fail++; $display("FAIL glitch_pulse_code: got %0d expected %0d", obs_q[rd_idx], e); end
            rd_idx++;
        end
        exp_q.delete();
        keys = 16'h0000;
        wait_frames(4);
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL glitch_full_release: got %b expected 0", kif.key_held); end
        keys = 16'h8000;
        exp_q.push_back(4'd15);
        wait_frames(4);
        keys = 16'h0000;
        wait_frames(4);
        n_checks++;
        if (!(obs_q.size() == rd_idx + exp_q.size() || (REP && obs_q.size() > rd_idx + exp_q.size()))) begin
            n_fail++; $display("FAIL glitch_repress_count: got %0d expected %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (obs_q[rd_idx] !== e) begin n_fail++; $display("FAIL glitch_repress_code: got %0d expected %0d", obs_q[rd_idx], e); end
            rd_idx++;
        end
        exp_q.delete();
    endtask

    task automatic test_repeat();
        int base;
        base = obs_q.size();
        keys = 16'h0020;
        exp_q.push_back(4'd5);
        for (int i = 0; i < 5 * FR && obs_q.size() == base; i++) @(negedge CCLK);
        n_checks++;
        if (obs_q.size() == base) begin n_fail++; $display("FAIL repeat_accept_timeout: got 0 pulses expected 1"); end
        if (REP) repeat (3) exp_q.push_back(4'd5);
        repeat (10 * FR + 4) @(negedge CCLK);
        keys = 16'h0000;
        wait_frames(4);
        n_checks++; if (kif.key_held !== 1'b0) begin n_fail++; $display("FAIL repeat_released: got %b expected 0", kif.key_held); end
        n_checks++;
        if (obs_q.size() != rd_idx + exp_q.size()) begin
            n_fail++; $display("FAIL repeat_pulse_count: got %0d expected %0d", obs_q.size() - rd_idx, exp_q.size());
        end
        while (rd_idx < obs_q.size()) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            n_checks++;
            if (obs_q[rd_idx] !== e) begin n_fail++; $display("FAIL repeat_pulse_code: got %0d expected %0d", obs_q[rd_idx], e); end
            rd_idx++;
        end
        exp_q.delete();
`ifdef KEYPAD_REPEAT_EN
        for (int i = base + 1; i < obs_cyc.size() && i <= base + 3; i++) begin
            n_checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 3 * FR) begin
                n_fail++; $display("FAIL repeat_spacing: got %0d cycles expected %0d", obs_cyc[i] - obs_cyc[i-1], 3 * FR);
            end
        end
`endif
    endtask

    initial begin
        #2 RST_N = 1'b0;
        test_reset();
        test_press();
        test_bounce();
        test_chord();
        test_release_glitch();
        test_repeat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1);
    end

endmodule
